// File: rtl/digit_scanner.sv
// Four-digit multiplexed BCD display scanner.
// Double-buffered data is committed at frame boundaries.
module digit_scanner #(
  parameter int unsigned DIV = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOAD,
  input  logic [15:0] DATA,
  input  logic        BLANK_LZ,
  output logic [3:0]  DIGIT,
  output logic [3:0]  AN,
  output logic        PENDING,
  output logic        FRAME
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [15:0]   active;
  logic          tick;
  logic          boundary;
  logic [3:0]    nz;
  logic [3:0]    blank;
  logic [3:0]    nib;

  assign tick     = (cnt == LAST);
  assign boundary = tick && (idx == 2'd3);

  // Prescaler and digit index advance.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow/active buffering; a load on the boundary bypasses the shadow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow  <= '0;
      active  <= '0;
      PENDING <= 1'b0;
    end else if (LOAD) begin
      shadow <= DATA;
      if (boundary) begin
        active  <= DATA;
        PENDING <= 1'b0;
      end else begin
        PENDING <= 1'b1;
      end
    end else if (boundary && PENDING) begin
      active  <= shadow;
      PENDING <= 1'b0;
    end
  end

  // Frame pulse lands on the first cycle of digit 0.
  always_ff @(posedge CLK) begin
    if (RST) FRAME <= 1'b0;
    else     FRAME <= boundary;
  end

  // Leading-zero detection across the upper digits.
  always_comb begin
    nz[0]    = |active[3:0];
    nz[1]    = |active[7:4];
    nz[2]    = |active[11:8];
    nz[3]    = |active[15:12];
    blank[0] = 1'b0;
    blank[1] = BLANK_LZ & ~(nz[3] | nz[2] | nz[1]);
    blank[2] = BLANK_LZ & ~(nz[3] | nz[2]);
    blank[3] = BLANK_LZ & ~nz[3];
  end

  // Digit and anode select for the current slot.
  always_comb begin
    nib   = active[3:0];
    DIGIT = 4'hF;
    AN    = 4'b1111;
    unique case (idx)
      2'd0: nib = active[3:0];
      2'd1: nib = active[7:4];
      2'd2: nib = active[11:8];
      2'd3: nib = active[15:12];
    endcase
    if (!blank[idx]) begin
      DIGIT = nib;
      AN    = ~(4'b0001 << idx);
    end
  end

endmodule
